// File: rtl/lsu_ahb_master.sv
// ---------------------------------------------------------------------------
// lsu_ahb_master
//   Bridges the core LSU valid/ready request/response channels onto a single
//   AHB-Lite master port. Non-pipelined: at most one transfer is outstanding.
//   Stores are lane-replicated onto hwdata. Loads have the addressed lane
//   extracted and then sign or zero extended. Illegal or misaligned requests
//   are answered with an error response and never reach the bus.
//
// Ports
//   clk, rstn        system clock, asynchronous active-low reset
//   lsu_req_*        LSU request channel (vld/rdy, wen, rwtyp=funct3, addr, wdata)
//   lsu_rsp_*        LSU response channel (vld/rdy, rdata, err)
//   haddr..hwdata    AHB-Lite master address/control/write-data outputs
//   hrdata, hready,
//   hresp            AHB-Lite read data, transfer-done and error inputs
//
// Parameters
//   HPROT_VAL        constant protection attributes driven on every transfer
//   MISALIGN_CHK     1: misaligned access is rejected with an error
//                    0: address is forced down to the access-size alignment
// ---------------------------------------------------------------------------
module lsu_ahb_master #(
  parameter logic [3:0] HPROT_VAL    = 4'b0011,
  parameter bit         MISALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lsu_req_vld,
  output logic        lsu_req_rdy,
  input  logic        lsu_req_wen,
  input  logic [2:0]  lsu_req_rwtyp,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  output logic        lsu_rsp_vld,
  input  logic        lsu_rsp_rdy,
  output logic [31:0] lsu_rsp_rdata,
  output logic        lsu_rsp_err,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t      state;
  logic        wen_q;
  logic [2:0]  rwtyp_q;
  logic [1:0]  lane_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] req_addr_aln;
  logic [31:0] req_wdata_lanes;

  assign hburst = 3'b000;
  assign hprot  = HPROT_VAL;

  // Load lane extraction followed by sign (rwtyp[2]=0) or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] d,
                                               input logic [2:0]  t,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (t[1:0])
      2'b00:   r = t[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = t[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request decode: legality, alignment, forced-aligned address and the
  // replicated store data. Alignment forcing is harmless when misaligned
  // requests are rejected, so the aligned address is always used.
  always_comb begin
    req_illegal     = (lsu_req_rwtyp == 3'b011) ||
                      (lsu_req_rwtyp[2:1] == 2'b11) ||
                      (lsu_req_wen && lsu_req_rwtyp[2]);
    req_misaligned  = 1'b0;
    req_addr_aln    = lsu_req_addr;
    req_wdata_lanes = lsu_req_wdata;
    case (lsu_req_rwtyp[1:0])
      2'b00: begin
        req_wdata_lanes = {4{lsu_req_wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned  = lsu_req_addr[0];
        req_addr_aln    = {lsu_req_addr[31:1], 1'b0};
        req_wdata_lanes = {2{lsu_req_wdata[15:0]}};
      end
      2'b10: begin
        req_misaligned  = |lsu_req_addr[1:0];
        req_addr_aln    = {lsu_req_addr[31:2], 2'b00};
      end
      default: begin
        req_misaligned  = 1'b0;
      end
    endcase
  end

  // Main FSM with all bus and LSU outputs registered. A rejected request
  // skips straight to RESP so no bus cycle is ever started for it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      lsu_req_rdy   <= 1'b1;
      lsu_rsp_vld   <= 1'b0;
      lsu_rsp_rdata <= 32'd0;
      lsu_rsp_err   <= 1'b0;
      htrans        <= HTRANS_IDLE;
      haddr         <= 32'd0;
      hwrite        <= 1'b0;
      hsize         <= 3'b000;
      hwdata        <= 32'd0;
      wen_q         <= 1'b0;
      rwtyp_q       <= 3'b000;
      lane_q        <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lsu_req_vld) begin
            lsu_req_rdy <= 1'b0;
            if (req_illegal || (MISALIGN_CHK && req_misaligned)) begin
              state         <= ST_RESP;
              lsu_rsp_vld   <= 1'b1;
              lsu_rsp_rdata <= 32'd0;
              lsu_rsp_err   <= 1'b1;
            end else begin
              state   <= ST_ADDR;
              htrans  <= HTRANS_NONSEQ;
              haddr   <= req_addr_aln;
              hwrite  <= lsu_req_wen;
              hsize   <= {1'b0, lsu_req_rwtyp[1:0]};
              hwdata  <= lsu_req_wen ? req_wdata_lanes : 32'd0;
              wen_q   <= lsu_req_wen;
              rwtyp_q <= lsu_req_rwtyp;
              lane_q  <= req_addr_aln[1:0];
            end
          end
        end
        ST_ADDR: begin
          if (hready) begin
            state  <= ST_DATA;
            htrans <= HTRANS_IDLE;
          end
        end
        ST_DATA: begin
          // The first cycle of a two-cycle ERROR has hready low and is
          // simply waited through; the error is taken with hready high.
          if (hready) begin
            state         <= ST_RESP;
            lsu_rsp_vld   <= 1'b1;
            lsu_rsp_err   <= hresp;
            lsu_rsp_rdata <= (hresp || wen_q) ? 32'd0
                                              : load_extract(hrdata, rwtyp_q, lane_q);
          end
        end
        ST_RESP: begin
          if (lsu_rsp_rdy) begin
            state         <= ST_IDLE;
            lsu_rsp_vld   <= 1'b0;
            lsu_rsp_rdata <= 32'd0;
            lsu_rsp_err   <= 1'b0;
            lsu_req_rdy   <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          lsu_req_rdy <= 1'b1;
          lsu_rsp_vld <= 1'b0;
          htrans      <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule
